// File: rtl/wb_mux_wdt.sv
// Single-master, N-slave Wishbone classic decoder/multiplexer.
// A registered slave select routes one transfer at a time. Unmapped accesses and
// transfers that hang past the watchdog limit are terminated with err, and the
// faulting address is logged.
module wb_mux_wdt #(
    parameter int unsigned                  NUM_SLAVES = 9,
    parameter logic [32*NUM_SLAVES-1:0]     MATCH_ADDR = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]     MATCH_MASK = {NUM_SLAVES{32'h0}},
    parameter int unsigned                  TIMEOUT    = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master request
    input  logic [31:0]                 wbm_adr_i,
    input  logic [31:0]                 wbm_dat_i,
    input  logic [3:0]                  wbm_sel_i,
    input  logic                        wbm_we_i,
    input  logic                        wbm_cyc_i,
    input  logic                        wbm_stb_i,
    input  logic [2:0]                  wbm_cti_i,
    input  logic [1:0]                  wbm_bte_i,
    // master response
    output logic [31:0]                 wbm_dat_o,
    output logic                        wbm_ack_o,
    output logic                        wbm_err_o,
    output logic                        wbm_rty_o,
    // slave requests
    output logic [32*NUM_SLAVES-1:0]    wbs_adr_o,
    output logic [32*NUM_SLAVES-1:0]    wbs_dat_o,
    output logic [4*NUM_SLAVES-1:0]     wbs_sel_o,
    output logic [NUM_SLAVES-1:0]       wbs_we_o,
    output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]       wbs_stb_o,
    output logic [3*NUM_SLAVES-1:0]     wbs_cti_o,
    output logic [2*NUM_SLAVES-1:0]     wbs_bte_o,
    // slave responses
    input  logic [32*NUM_SLAVES-1:0]    wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]       wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]       wbs_err_i,
    input  logic [NUM_SLAVES-1:0]       wbs_rty_i,
    // error reporting
    output logic                        timeout_o,
    output logic [31:0]                 err_adr_o,
    output logic [7:0]                  err_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DECERR,
        S_TOERR
    } state_t;

    localparam bit          P_WDT_EN  = (TIMEOUT != 0);
    localparam logic [15:0] P_TO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [4:0]  r_sel;
    logic [15:0] r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_err_adr;
    logic [7:0]  r_err_cnt;

    logic        w_hit;
    logic [4:0]  w_idx;
    logic        w_active;
    logic        w_s_ack;
    logic        w_s_err;
    logic        w_s_rty;
    logic        w_s_resp;
    logic [31:0] w_s_dat;

    // Request fields are broadcast unregistered to every slave slice.
    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
    assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

    assign w_active = (r_state == S_ACTIVE);

    // Address decode; scanning from the top down leaves the lowest matching index.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int unsigned i = NUM_SLAVES; i > 0; i--) begin
            if ((wbm_adr_i & MATCH_MASK[32*(i-1) +: 32]) == MATCH_ADDR[32*(i-1) +: 32]) begin
                w_hit = 1'b1;
                w_idx = 5'(i - 1);
            end
        end
    end

    // Pick the response lines of the latched slave; all others are ignored.
    always_comb begin
        w_s_ack = 1'b0;
        w_s_err = 1'b0;
        w_s_rty = 1'b0;
        w_s_dat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel == 5'(i)) begin
                w_s_ack = wbs_ack_i[i];
                w_s_err = wbs_err_i[i];
                w_s_rty = wbs_rty_i[i];
                w_s_dat = wbs_dat_i[32*i +: 32];
            end
        end
    end

    assign w_s_resp = w_s_ack | w_s_err | w_s_rty;

    // Only the selected slave sees cyc/stb, and only while a transfer is active.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        if (w_active) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (r_sel == 5'(i)) begin
                    wbs_cyc_o[i] = wbm_cyc_i;
                    wbs_stb_o[i] = wbm_cyc_i & wbm_stb_i;
                end
            end
        end
    end

    assign wbm_ack_o = w_active & w_s_ack;
    assign wbm_rty_o = w_active & w_s_rty;
    assign wbm_err_o = (w_active & w_s_err) | (r_state == S_DECERR) | (r_state == S_TOERR);
    assign wbm_dat_o = w_active ? w_s_dat : '0;
    assign timeout_o = (r_state == S_TOERR);
    assign err_adr_o = r_err_adr;
    assign err_cnt_o = r_err_cnt;

    // Transfer FSM with watchdog and error logging.
    // The error address/count are loaded on the transition into DECERR/TOERR so
    // they are already valid during the err cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_adr     <= '0;
            r_err_adr <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        r_adr <= wbm_adr_i;
                        if (w_hit) begin
                            r_sel   <= w_idx;
                            r_cnt   <= '0;
                            r_state <= S_ACTIVE;
                        end else begin
                            r_err_adr <= wbm_adr_i;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            r_state <= S_DECERR;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!wbm_cyc_i || w_s_resp) begin
                        r_state <= S_IDLE;
                    end else if (P_WDT_EN && (r_cnt == P_TO_LAST)) begin
                        r_err_adr <= r_adr;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state <= S_TOERR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DECERR: r_state <= S_IDLE;
                S_TOERR:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mux_wdt.sv
// Scoreboard bench for wb_mux_wdt: stimulus pushes expected responses, a
// negedge monitor pops and compares whenever the mux presents a response.
module tb_wb_mux_wdt;

    localparam int unsigned NS = 9;
    localparam int unsigned TO = 16;

    // slave 8 (broad) and slave 7 (narrow) overlap on 0x1000..0x103f
    localparam logic [32*NS-1:0] P_ADDR = {
        32'h0000_1000, 32'h0000_1000, 32'h8006_0000, 32'h8005_0000, 32'h8004_0000,
        32'h8003_0000, 32'h8002_0000, 32'h0000_2000, 32'h0000_0000};
    localparam logic [32*NS-1:0] P_MASK = {
        32'hFFFF_F000, 32'hFFFF_FFC0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic               clk;
    logic               rst;
    logic [31:0]        m_adr;
    logic [31:0]        m_dat;
    logic [3:0]         m_sel;
    logic               m_we;
    logic               m_cyc;
    logic               m_stb;
    logic [2:0]         m_cti;
    logic [1:0]         m_bte;
    logic [31:0]        wbm_dat_o;
    logic               wbm_ack_o;
    logic               wbm_err_o;
    logic               wbm_rty_o;
    logic [32*NS-1:0]   wbs_adr_o;
    logic [32*NS-1:0]   wbs_dat_o;
    logic [4*NS-1:0]    wbs_sel_o;
    logic [NS-1:0]      wbs_we_o;
    logic [NS-1:0]      wbs_cyc_o;
    logic [NS-1:0]      wbs_stb_o;
    logic [3*NS-1:0]    wbs_cti_o;
    logic [2*NS-1:0]    wbs_bte_o;
    wire  [32*NS-1:0]   wbs_dat_i;
    wire  [NS-1:0]      wbs_ack_i;
    logic [NS-1:0]      wbs_err_i;
    logic [NS-1:0]      wbs_rty_i;
    logic               timeout_o;
    logic [31:0]        err_adr_o;
    logic [7:0]         err_cnt_o;

    wb_mux_wdt #(
        .NUM_SLAVES (NS),
        .MATCH_ADDR (P_ADDR),
        .MATCH_MASK (P_MASK),
        .TIMEOUT    (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (m_adr),
        .wbm_dat_i (m_dat),
        .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),
        .wbm_cyc_i (m_cyc),
        .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),
        .wbm_bte_i (m_bte),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i),
        .timeout_o (timeout_o),
        .err_adr_o (err_adr_o),
        .err_cnt_o (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Slave models: slave i acks on the slv_delay[i]-th cycle its stb is high (0 = never).
    logic [7:0]  slv_delay [NS];
    logic [7:0]  slv_cnt   [NS];
    logic [31:0] slv_data  [NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            slv_cnt[i] <= wbs_stb_o[i] ? slv_cnt[i] + 8'd1 : 8'd0;
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_slv
        assign wbs_ack_i[g] = wbs_stb_o[g] && (slv_delay[g] != 8'd0) &&
                              (slv_cnt[g] == slv_delay[g] - 8'd1);
        assign wbs_dat_i[32*g +: 32] = slv_data[g];
    end

    typedef struct {
        bit          is_err;
        bit          to;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [31:0] eadr;
        logic [7:0]  ecnt;
        int unsigned cyc_at;
        int unsigned sel;
        int unsigned stb_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  exp_cnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin : monitor
        exp_t        e;
        int unsigned stb_run;
        stb_run = 0;
        forever begin
            @(negedge clk);
            if (!m_cyc) stb_run = 0;
            else if (|wbs_stb_o) stb_run++;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: ack=%b err=%b rty=%b at cycle %0d, expected none",
                             wbm_ack_o, wbm_err_o, wbm_rty_o, cyc_n);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc_n, e.cyc_at);
                    chk("err", {31'd0, wbm_err_o}, {31'd0, e.is_err});
                    chk("ack", {31'd0, wbm_ack_o}, {31'd0, !e.is_err});
                    chk("rty", {31'd0, wbm_rty_o}, 32'd0);
                    chk("timeout_o", {31'd0, timeout_o}, {31'd0, e.to});
                    chk("stb_cycles", stb_run, e.stb_cyc);
                    if (e.is_err) begin
                        chk("err_adr", err_adr_o, e.eadr);
                        chk("err_cnt", {24'd0, err_cnt_o}, {24'd0, e.ecnt});
                        chk("cyc_off", {23'd0, wbs_cyc_o}, 32'd0);
                        chk("stb_off", {23'd0, wbs_stb_o}, 32'd0);
                    end else begin
                        chk("rd_dat", wbm_dat_o, e.dat);
                        chk("stb_sel", {23'd0, wbs_stb_o}, 32'd1 << e.sel);
                        chk("adr_bcast", wbs_adr_o[32*e.sel +: 32], e.adr);
                    end
                end
            end
        end
    end

    // One master transfer; lat = response cycle counted from the stb cycle.
    task automatic issue(input logic [31:0] adr, input logic we, input bit is_err, input bit to,
                         input int unsigned sel, input int unsigned lat, input int unsigned stb_cyc);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        e.is_err  = is_err;
        e.to      = to;
        e.adr     = adr;
        e.sel     = sel;
        e.dat     = is_err ? 32'd0 : slv_data[sel];
        e.cyc_at  = cyc_n + lat;
        e.stb_cyc = stb_cyc;
        if (is_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.eadr    = adr;
        e.ecnt    = exp_cnt;
        sb.push_back(e);
        m_adr = adr;
        m_dat = adr ^ 32'h5555_5555;
        m_we  = we;
        m_sel = 4'hF;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL no_response: adr 0x%h got none expected response within 100 cycles", adr);
        end
        @(posedge clk);
        #1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
    endtask

    // Starts a transfer to a never-acking slave and stops at cycle 2.
    task automatic start_hang(input logic [31:0] adr);
        @(posedge clk);
        #1;
        m_adr = adr;
        m_we  = 1'b0;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        for (int i = 0; i < NS; i++) begin
            slv_delay[i] = 8'd0;
            slv_data[i]  = 32'hA5A5_0000 | i;
        end
        slv_data[7] = 32'hDEAD_BEEF;
        wbs_err_i = '0;
        wbs_rty_i = '0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = '0; m_bte = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, wbm_ack_o}, 32'd0);
        chk("rst_err", {31'd0, wbm_err_o}, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_stb", {23'd0, wbs_stb_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rst_err_adr", err_adr_o, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        rst = 1'b0;

        // read to slave 7, ack at cycle 3
        slv_delay[7] = 8'd3;
        issue(32'h0000_1000, 1'b0, 1'b0, 1'b0, 7, 3, 3);
        // unmapped write
        issue(32'h0000_3000, 1'b1, 1'b1, 1'b0, 0, 1, 0);
        // hung slave 1 -> watchdog at TIMEOUT+1
        slv_delay[1] = 8'd0;
        issue(32'h0000_2000, 1'b0, 1'b1, 1'b1, 1, TO + 1, TO);
        // ack on the last watchdog cycle wins
        slv_delay[1] = 8'd16;
        issue(32'h0000_2010, 1'b0, 1'b0, 1'b0, 1, 16, 16);
        // overlap: lowest index (7) wins over broader slave 8
        issue(32'h0000_1004, 1'b0, 1'b0, 1'b0, 7, 3, 3);
        // only slave 8 covers 0x1040
        slv_delay[8] = 8'd1;
        issue(32'h0000_1040, 1'b1, 1'b0, 1'b0, 8, 1, 1);
        // slave 0 top of range
        slv_delay[0] = 8'd2;
        issue(32'h0000_0FFC, 1'b0, 1'b0, 1'b0, 0, 2, 2);

        // abort by dropping cyc at cycle 2
        slv_delay[1] = 8'd0;
        start_hang(32'h0000_2000);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        #1;
        chk("abort_stb", {23'd0, wbs_stb_o}, 32'd0);
        chk("abort_cyc", {23'd0, wbs_cyc_o}, 32'd0);
        repeat (TO + 8) @(posedge clk);
        #1;
        chk("abort_err_cnt", {24'd0, err_cnt_o}, {24'd0, exp_cnt});
        chk("abort_err_adr", err_adr_o, 32'h0000_2000);

        // asynchronous reset at cycle 2 of an active transfer
        start_hang(32'h0000_2000);
        rst = 1'b1;
        #1;
        exp_cnt = 8'd0;
        chk("arst_stb", {23'd0, wbs_stb_o}, 32'd0);
        chk("arst_ack", {31'd0, wbm_ack_o}, 32'd0);
        chk("arst_err", {31'd0, wbm_err_o}, 32'd0);
        chk("arst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        chk("arst_err_adr", err_adr_o, 32'd0);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (TO + 4) @(posedge clk);

        // 300 unmapped accesses saturate the error counter
        for (int i = 0; i < 300; i++) begin
            issue(32'h0000_3000 + 32'(i) * 32'h10, 1'b0, 1'b1, 1'b0, 0, 1, 0);
        end
        #1;
        chk("err_cnt_sat", {24'd0, err_cnt_o}, 32'd255);

        repeat (4) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
